// File: rtl/thread_scheduler_pkg.sv
// Shared types and constants for the barrel-thread scheduler.
// Imported by the scheduler top and its testbench.
package thread_scheduler_pkg;

    localparam int NUM_THREADS_DEF = 4;
    localparam int TID_W = $clog2(NUM_THREADS_DEF);
    localparam int PC_INC = 4;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } thr_state_e;

endpackage

// File: rtl/thread_scheduler_if.sv
// Scheduler bundle: control/start/resolve inputs, issue/status outputs.
// master drives the scheduler, slave is the scheduler itself.
interface thread_scheduler_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = 4
);
    localparam int TW = $clog2(NUM_THREADS);

    logic                     stall;
    logic                     start_valid;
    logic [TW-1:0]            start_tid;
    logic [ADDRESS_WIDTH-1:0] start_pc;
    logic                     start_ready;
    logic                     resolve_valid;
    logic [TW-1:0]            resolve_tid;
    logic                     resolve_redirect;
    logic [ADDRESS_WIDTH-1:0] resolve_target;
    logic                     resolve_halt;
    logic                     issue_valid;
    logic [TW-1:0]            issue_tid;
    logic [ADDRESS_WIDTH-1:0] issue_pc;
    logic [NUM_THREADS-1:0]   active_mask;
    logic                     all_idle;

    modport master (
        output stall, start_valid, start_tid, start_pc,
        output resolve_valid, resolve_tid, resolve_redirect,
        output resolve_target, resolve_halt,
        input  start_ready, issue_valid, issue_tid, issue_pc,
        input  active_mask, all_idle
    );

    modport slave (
        input  stall, start_valid, start_tid, start_pc,
        input  resolve_valid, resolve_tid, resolve_redirect,
        input  resolve_target, resolve_halt,
        output start_ready, issue_valid, issue_tid, issue_pc,
        output active_mask, all_idle
    );

endinterface

// File: rtl/thread_scheduler_rr_picker.sv
// Rotate-priority selector: first requester after ptr_i, with wrap.
// Purely combinational so it can be reused by other arbiters.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 grant_valid_o,
    output logic [$clog2(N)-1:0] grant_tid_o
);
    localparam int TW = $clog2(N);

    logic [TW-1:0] idx;

    // Walk farthest offset first so the nearest requester wins last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_tid_o   = '0;
        idx           = '0;
        for (int i = N; i >= 1; i--) begin
            idx = ptr_i + TW'(i);
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_tid_o   = idx;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin barrel scheduler: one (tid, pc) per cycle to fetch,
// with a per-thread in-flight interlock released by execute.
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = NUM_THREADS_DEF,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter logic [NUM_THREADS-1:0] RESET_MASK = '1
) (
    input  logic               clk,
    input  logic               rst,
    thread_scheduler_if.slave  bus
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int NT = NUM_THREADS;

    typedef logic [ADDRESS_WIDTH-1:0] pc_t;

    pc_t           pc_q   [NT];
    pc_t           pc_d   [NT];
    thr_state_e    run_q  [NT];
    thr_state_e    run_d  [NT];
    logic [NT-1:0] infl_q;
    logic [NT-1:0] infl_d;
    logic [TW-1:0] rr_q;
    logic [TW-1:0] rr_d;
    logic          iv_q;
    logic          iv_d;
    logic [TW-1:0] itid_q;
    logic [TW-1:0] itid_d;
    pc_t           ipc_q;
    pc_t           ipc_d;

    logic [NT-1:0] elig;
    logic [NT-1:0] run_mask;
    logic          gv;
    logic [TW-1:0] gt;
    logic          start_rdy;

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            run_mask[i] = (run_q[i] == T_RUN);
            elig[i]     = run_mask[i] && !infl_q[i];
        end
    end

    rr_picker #(
        .N (NT)
    ) u_pick (
        .req_i         (elig),
        .ptr_i         (rr_q),
        .grant_valid_o (gv),
        .grant_tid_o   (gt)
    );

    assign start_rdy = !run_mask[bus.start_tid] &&
                       !infl_q[bus.start_tid];

    always_comb begin
        pc_d   = pc_q;
        run_d  = run_q;
        infl_d = infl_q;
        rr_d   = rr_q;
        iv_d   = iv_q;
        itid_d = itid_q;
        ipc_d  = ipc_q;

        if (!bus.stall) begin
            iv_d = gv;
            if (gv) begin
                itid_d     = gt;
                ipc_d      = pc_q[gt];
                pc_d[gt]   = pc_q[gt] + pc_t'(PC_INC);
                infl_d[gt] = 1'b1;
                rr_d       = gt;
            end
        end

        // Halt takes priority over a same-cycle redirect.
        if (bus.resolve_valid) begin
            infl_d[bus.resolve_tid] = 1'b0;
            if (bus.resolve_halt) begin
                run_d[bus.resolve_tid] = T_IDLE;
            end else if (bus.resolve_redirect) begin
                pc_d[bus.resolve_tid] = bus.resolve_target;
            end
        end

        if (bus.start_valid && start_rdy) begin
            run_d[bus.start_tid] = T_RUN;
            pc_d[bus.start_tid]  = bus.start_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NT; i++) begin
                pc_q[i]  <= RESET_PC;
                run_q[i] <= RESET_MASK[i] ? T_RUN : T_IDLE;
            end
            infl_q <= '0;
            rr_q   <= TW'(NT - 1);
            iv_q   <= 1'b0;
            itid_q <= '0;
            ipc_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            run_q  <= run_d;
            infl_q <= infl_d;
            rr_q   <= rr_d;
            iv_q   <= iv_d;
            itid_q <= itid_d;
            ipc_q  <= ipc_d;
        end
    end

    assign bus.start_ready = start_rdy;
    assign bus.issue_valid = iv_q;
    assign bus.issue_tid   = itid_q;
    assign bus.issue_pc    = ipc_q;
    assign bus.active_mask = run_mask;
    assign bus.all_idle    = !(|run_mask) && !(|infl_q);

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench: two schedulers (all threads / tid0 only) driven by a
// small execute model that resolves every issue three cycles later.
module tb_thread_scheduler;

    localparam int AW = 32;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    thread_scheduler_if #(.ADDRESS_WIDTH(AW), .NUM_THREADS(NT)) bus0 ();
    thread_scheduler_if #(.ADDRESS_WIDTH(AW), .NUM_THREADS(NT)) bus1 ();

    thread_scheduler #(
        .ADDRESS_WIDTH (AW),
        .NUM_THREADS   (NT),
        .RESET_PC      (32'h0),
        .RESET_MASK    (4'b1111)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    thread_scheduler #(
        .ADDRESS_WIDTH (AW),
        .NUM_THREADS   (NT),
        .RESET_PC      (32'h0),
        .RESET_MASK    (4'b0001)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic        dv      [2][2];
    logic [1:0]  dt      [2][2];
    logic        halt_on [2];
    logic [1:0]  halt_t  [2];
    logic        red_on  [2];
    logic [1:0]  red_t   [2];
    logic [31:0] red_pc  [2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic v, input logic [1:0] t,
                                       input logic [31:0] pc);
        return {29'b0, v, t, pc};
    endfunction

    function automatic logic [63:0] obs0();
        return pk(bus0.issue_valid, bus0.issue_tid, bus0.issue_pc);
    endfunction

    function automatic logic [63:0] obs1();
        return pk(bus1.issue_valid, bus1.issue_tid, bus1.issue_pc);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                dv[d][k] = 1'b0;
                dt[d][k] = 2'd0;
            end
            halt_on[d] = 1'b0;
            halt_t[d]  = 2'd0;
            red_on[d]  = 1'b0;
            red_t[d]   = 2'd0;
            red_pc[d]  = 32'h0;
        end
    endtask

    task automatic exec_model(input int d, input logic v, input logic [1:0] t,
                              input logic st, output logic rv,
                              output logic [1:0] rt, output logic rr,
                              output logic [31:0] rg, output logic rh);
        rv = dv[d][1];
        rt = dt[d][1];
        rr = 1'b0;
        rh = 1'b0;
        rg = 32'h0;
        if (rv && halt_on[d] && halt_t[d] == rt) begin
            rh = 1'b1;
            rr = 1'b1;
            rg = 32'h3C;
            halt_on[d] = 1'b0;
        end else if (rv && red_on[d] && red_t[d] == rt) begin
            rr = 1'b1;
            rg = red_pc[d];
            red_on[d] = 1'b0;
        end
        dv[d][1] = dv[d][0];
        dt[d][1] = dt[d][0];
        dv[d][0] = v & ~st;
        dt[d][0] = t;
    endtask

    task automatic do_cycle();
        logic        st;
        logic        rv;
        logic        rr;
        logic        rh;
        logic [1:0]  rt;
        logic [31:0] rg;
        st = bus0.stall;
        @(posedge clk);
        #1;
        exec_model(0, bus0.issue_valid, bus0.issue_tid, st, rv, rt, rr, rg, rh);
        bus0.resolve_valid    = rv;
        bus0.resolve_tid      = rt;
        bus0.resolve_redirect = rr;
        bus0.resolve_target   = rg;
        bus0.resolve_halt     = rh;
        exec_model(1, bus1.issue_valid, bus1.issue_tid, 1'b0, rv, rt, rr, rg, rh);
        bus1.resolve_valid    = rv;
        bus1.resolve_tid      = rt;
        bus1.resolve_redirect = rr;
        bus1.resolve_target   = rg;
        bus1.resolve_halt     = rh;
    endtask

    task automatic iss0(input string tag, input logic v, input logic [1:0] t,
                        input logic [31:0] pc);
        do_cycle();
        chk(tag, obs0(), pk(v, t, pc));
    endtask

    task automatic drive_idle();
        bus0.stall = 1'b0;
        bus1.stall = 1'b0;
        bus0.start_valid = 1'b0;
        bus1.start_valid = 1'b0;
        bus0.start_tid = 2'd0;
        bus1.start_tid = 2'd0;
        bus0.start_pc = 32'h0;
        bus1.start_pc = 32'h0;
        bus0.resolve_valid = 1'b0;
        bus1.resolve_valid = 1'b0;
        bus0.resolve_tid = 2'd0;
        bus1.resolve_tid = 2'd0;
        bus0.resolve_redirect = 1'b0;
        bus1.resolve_redirect = 1'b0;
        bus0.resolve_target = 32'h0;
        bus1.resolve_target = 32'h0;
        bus0.resolve_halt = 1'b0;
        bus1.resolve_halt = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_clear();
        #12;
        chk("rst_issue0", obs0(), pk(1'b0, 2'd0, 32'h0));
        chk("rst_issue1", obs1(), pk(1'b0, 2'd0, 32'h0));
        chk("rst_mask0", 64'(bus0.active_mask), 64'h0F);
        chk("rst_mask1", 64'(bus1.active_mask), 64'h01);
        chk("rst_idle0", 64'(bus0.all_idle), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int s = 1; s <= 9; s++) begin
            do_cycle();
            chk($sformatf("rr_all_%0d", s), obs0(),
                pk(1'b1, 2'((s - 1) % 4), 32'(4 * ((s - 1) / 4))));
            chk($sformatf("one_thr_%0d", s), obs1(),
                pk((s % 4) == 1, 2'd0, 32'(4 * ((s - 1) / 4))));
        end

        red_on[0]  = 1'b1;
        red_t[0]   = 2'd2;
        red_pc[0]  = 32'h40;
        halt_on[1] = 1'b1;
        halt_t[1]  = 2'd0;

        iss0("s10", 1'b1, 2'd1, 32'h8);
        chk("one_bub10", obs1(), pk(1'b0, 2'd0, 32'h8));
        iss0("s11", 1'b1, 2'd2, 32'h8);
        chk("one_busy11", 64'(bus1.all_idle), 64'h0);
        iss0("s12", 1'b1, 2'd3, 32'h8);
        chk("one_idle12", 64'(bus1.all_idle), 64'h1);
        chk("one_mask12", 64'(bus1.active_mask), 64'h0);
        iss0("s13", 1'b1, 2'd0, 32'hC);
        iss0("s14", 1'b1, 2'd1, 32'hC);
        iss0("redir15", 1'b1, 2'd2, 32'h40);
        iss0("s16", 1'b1, 2'd3, 32'hC);
        iss0("s17", 1'b1, 2'd0, 32'h10);
        iss0("s18", 1'b1, 2'd1, 32'h10);
        iss0("redir19", 1'b1, 2'd2, 32'h44);

        halt_on[0] = 1'b1;
        halt_t[0]  = 2'd1;
        iss0("s20", 1'b1, 2'd3, 32'h10);
        iss0("s21", 1'b1, 2'd0, 32'h14);
        chk("halt_mask", 64'(bus0.active_mask), 64'hD);
        iss0("bub22", 1'b0, 2'd0, 32'h14);
        iss0("s23", 1'b1, 2'd2, 32'h48);
        iss0("s24", 1'b1, 2'd3, 32'h14);
        iss0("s25", 1'b1, 2'd0, 32'h18);
        iss0("bub26", 1'b0, 2'd0, 32'h18);
        iss0("s27", 1'b1, 2'd2, 32'h4C);
        iss0("s28", 1'b1, 2'd3, 32'h18);

        bus0.start_valid = 1'b1;
        bus0.start_tid   = 2'd1;
        bus0.start_pc    = 32'h100;
        #1;
        chk("start_rdy_idle", 64'(bus0.start_ready), 64'h1);
        iss0("s29", 1'b1, 2'd0, 32'h1C);
        bus0.start_valid = 1'b0;
        iss0("start30", 1'b1, 2'd1, 32'h100);
        chk("start_mask", 64'(bus0.active_mask), 64'hF);
        iss0("s31", 1'b1, 2'd2, 32'h50);
        iss0("s32", 1'b1, 2'd3, 32'h1C);
        iss0("s33", 1'b1, 2'd0, 32'h20);
        iss0("s34", 1'b1, 2'd1, 32'h104);

        bus0.stall = 1'b1;
        for (int s = 35; s <= 37; s++) begin
            iss0($sformatf("stall%0d", s), 1'b1, 2'd1, 32'h104);
        end
        bus0.stall = 1'b0;
        iss0("resume38", 1'b1, 2'd2, 32'h54);
        iss0("s39", 1'b1, 2'd3, 32'h20);
        iss0("s40", 1'b1, 2'd0, 32'h24);
        iss0("s41", 1'b1, 2'd1, 32'h108);

        bus0.start_valid = 1'b1;
        bus0.start_tid   = 2'd3;
        bus0.start_pc    = 32'h200;
        #1;
        chk("start_rdy_run", 64'(bus0.start_ready), 64'h0);
        iss0("s42", 1'b1, 2'd2, 32'h58);
        bus0.start_valid = 1'b0;
        iss0("nostart43", 1'b1, 2'd3, 32'h24);

        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(bus0.issue_valid), 64'h0);
        chk("arst_issue", obs0(), pk(1'b0, 2'd0, 32'h0));
        chk("arst_mask1", 64'(bus1.active_mask), 64'h1);
        drive_idle();
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        iss0("rerun1", 1'b1, 2'd0, 32'h0);
        chk("rerun1_one", obs1(), pk(1'b1, 2'd0, 32'h0));
        iss0("rerun2", 1'b1, 2'd1, 32'h0);
        iss0("rerun3", 1'b1, 2'd2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
Round-robin barrel scheduler for the multithreaded 5-stage RV32 pipeline. It holds one PC and one run state per hardware thread and issues one (tid, pc) per cycle to the fetch stage. It applies branch/jump redirects and halts reported by execute. A per-thread in-flight interlock guarantees that no thread fetches again until its previous instruction has resolved in execute, so correctness holds even when fewer than NUM_THREADS threads are running.

Parameters:
ADDRESS_WIDTH, 32, PC width
NUM_THREADS, 4, hardware threads (power of two, >=2)
RESET_PC, 0, PC loaded into every thread at reset
RESET_MASK, {NUM_THREADS{1'b1}}, threads in RUN after reset (bit i = tid i)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold issue outputs and all scheduler state except resolve/start updates
start_valid  in  1  request to launch a thread
start_tid  in  $clog2(NUM_THREADS)  thread to launch
start_pc  in  ADDRESS_WIDTH  launch PC
start_ready  out  1  combinational: thread start_tid is IDLE and not in flight
resolve_valid  in  1  execute reports one instruction resolved
resolve_tid  in  $clog2(NUM_THREADS)  owning thread
resolve_redirect  in  1  taken branch/jump (pc_src_e)
resolve_target  in  ADDRESS_WIDTH  redirect PC (pc_target_e)
resolve_halt  in  1  thread executed halt (ecall/ebreak)
issue_valid  out  1  registered: issue_tid/issue_pc valid this cycle
issue_tid  out  $clog2(NUM_THREADS)  registered thread id to fetch
issue_pc  out  ADDRESS_WIDTH  registered PC to fetch
active_mask  out  NUM_THREADS  bit i = thread i in RUN
all_idle  out  1  no thread in RUN and none in flight

Behaviour:
- Per-thread state: run bit (IDLE=0 / RUN=1), inflight bit, pc register.
- Round-robin pointer rr_ptr holds the tid of the last issue.
- Reset (rst=0, asynchronous):
  - pc[i]=RESET_PC; run[i]=RESET_MASK[i]; inflight=0.
  - rr_ptr=NUM_THREADS-1, so tid 0 has first priority.
  - issue_valid=0, issue_tid=0, issue_pc=0.
- Eligible thread: run=1 and inflight=0, judged on registered state.
- Selection: first eligible tid scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_THREADS.
- Each cycle with stall=0:
  - Eligible thread t exists: issue_valid<=1, issue_tid<=t, issue_pc<=pc[t]; pc[t]<=pc[t]+4 (wraps at 2^ADDRESS_WIDTH); inflight[t]<=1; rr_ptr<=t.
  - None eligible: issue_valid<=0 (bubble). issue_tid and issue_pc hold; rr_ptr holds.
- stall=1: issue outputs, rr_ptr and issue-side pc increments are frozen. Resolve and start updates are still applied.
- Resolve for thread r (resolve_valid=1):
  - inflight[r]<=0.
  - If resolve_halt: run[r]<=0; the redirect is ignored (halt wins).
  - Else if resolve_redirect: pc[r]<=resolve_target.
  - The cleared inflight takes effect next cycle; thread r is not eligible in the resolve cycle.
  - Resolve for a thread with inflight=0 is a protocol error. State is unchanged except the run/pc update above.
- Start:
  - start_valid and start_ready: run[s]<=1, pc[s]<=start_pc, applied at the clock edge.
  - start_valid without start_ready: ignored, no state change.
- Same-cycle resolve and start for the same tid: start_ready is 0 (inflight=1), so the start is ignored.
- Issue and resolve on the same tid cannot coincide, because the inflight interlock prevents it.
- A halted thread's PC is retained until restarted.
- active_mask and all_idle are combinational from the registered state.
- Issue latency: 1 cycle from eligibility to issue_valid.
- Minimum re-issue gap per thread: resolve latency + 1 cycles.

Decomposition:
- Shared package (cpu_pkg): TID_W = $clog2(NUM_THREADS), the thread-state encoding, and the PC increment constant 4.
- One natural sub-module, rr_picker: combinational rotate-priority selector taking an eligible mask and rr_ptr, returning grant_valid and grant_tid. It is reusable for a later dmem port arbiter.
- Per-thread state lives in the top module as arrays.

Test Plan:
1. Reset, RESET_MASK=4'b1111, bench resolves each issue 3 cycles later -> issue (tid,pc) = (0,0),(1,0),(2,0),(3,0),(0,4),(1,4); no bubbles.
2. RESET_MASK=4'b0001, resolve 3 cycles after issue -> tid0 issues pc 0,4,8 spaced 4 cycles apart; issue_valid=0 in between.
3. All running; tid2 resolve_redirect=1 with target 0x40 -> tid2's next issue_pc=0x40 and following issue 0x44; other threads unaffected.
4. tid1 resolve_halt=1 with redirect=1 -> active_mask=4'b1101 and tid1 never issues. Then start tid1 with pc 0x100 -> start_ready=1, tid1 next issue_pc=0x100.
5. stall=1 for 3 cycles mid-run -> issue outputs constant, rr_ptr unchanged; resumes with the next round-robin tid and unchanged PCs.
6. Assert rst mid-run (asynchronous, between edges) -> issue_valid=0 immediately; after release, sequence restarts at (0,RESET_PC). Also: start on a RUN thread -> start_ready=0 and no effect.
